mul_pipe: RTL and testbench

- Pipelined, handshaked integer multiplier; successor to the combinational tree multiplier.
- Supports RISC-V M-extension multiply ops (MUL, MULH, MULHSU, MULHU) with signed, unsigned and mixed operands.
- 3 register stages, throughput 1 op/cycle, full backpressure and flush.
- Sits between the execute-stage issue logic and writeback; reuses the existing dadda/wallace reduction trees.

---
 rtl/mul_pipe_pkg.sv | 52 +++++
 rtl/mul_pipe_trees.sv | 115 +++++++++++
 rtl/mul_pipe.sv | 142 ++++++++++++++
 tb/tb_mul_pipe.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pipe_pkg.sv
// mul_pipe_pkg: op encodings, operand signedness helpers and the
// per-level 3:2 compressor schedules used by the reduction trees.
package mul_pipe_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'd0;
  localparam logic [1:0] MUL_OP_MULH   = 2'd1;
  localparam logic [1:0] MUL_OP_MULHSU = 2'd2;
  localparam logic [1:0] MUL_OP_MULHU  = 2'd3;

  function automatic logic op_a_signed(
    input logic [1:0] op
  );
    return (op == MUL_OP_MULH) ||
           (op == MUL_OP_MULHSU);
  endfunction

  function automatic logic op_b_signed(
    input logic [1:0] op
  );
    return op == MUL_OP_MULH;
  endfunction

  function automatic logic op_hi(
    input logic [1:0] op
  );
    return op != MUL_OP_MUL;
  endfunction

  // Largest Dadda height (2,3,4,6,9,13,...) below n.
  function automatic int dadda_target(
    input int n
  );
    int d;
    d = 2;
    while ((d * 3) / 2 < n) d = (d * 3) / 2;
    return d;
  endfunction

  // Compressors per level; each one removes a row.
  function automatic int dadda_cmp(
    input int n
  );
    return (n > 2) ? n - dadda_target(n) : 0;
  endfunction

  function automatic int wallace_cmp(
    input int n
  );
    return (n > 2) ? n / 3 : 0;
  endfunction

endpackage

// File: rtl/mul_pipe_trees.sv
// dadda / wallace: partial-product reduction trees, a_i*b_i -> z0_o+z1_o.
// Ports: a_i, b_i (XLEN unsigned); z0_o, z1_o (2*XLEN carry-save pair).
module dadda
  import mul_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] z0_o,
  output logic [2*XLEN-1:0] z1_o
);

  localparam int W = 2 * XLEN;

  function automatic int rows_at(
    input int l
  );
    int n;
    n = XLEN;
    for (int i = 0; i < l; i++)
      n = n - dadda_cmp(n);
    return n;
  endfunction

  logic [W-1:0] lvl [XLEN+1][XLEN];

  for (genvar i = 0; i < XLEN; i++) begin : g_pp
    assign lvl[0][i] = b_i[i] ? (W'(a_i) << i) : '0;
  end

  for (genvar l = 0; l < XLEN; l++) begin : g_lvl
    localparam int N = rows_at(l);
    localparam int G = dadda_cmp(N);
    localparam int M = N - G;
    for (genvar j = 0; j < XLEN; j++) begin : g_row
      localparam int K = 3 * (j / 2);
      if (j < 2 * G && j % 2 == 0) begin : g_s
        assign lvl[l+1][j] = lvl[l][K] ^
                             lvl[l][K+1] ^
                             lvl[l][K+2];
      end else if (j < 2 * G) begin : g_c
        assign lvl[l+1][j] =
          ((lvl[l][K] & lvl[l][K+1]) |
           (lvl[l][K] & lvl[l][K+2]) |
           (lvl[l][K+1] & lvl[l][K+2])) << 1;
      end else if (j < M) begin : g_p
        assign lvl[l+1][j] = lvl[l][j+G];
      end else begin : g_z
        assign lvl[l+1][j] = '0;
      end
    end
  end

  assign z0_o = lvl[XLEN][0];
  assign z1_o = lvl[XLEN][1];

endmodule

module wallace
  import mul_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] z0_o,
  output logic [2*XLEN-1:0] z1_o
);

  localparam int W = 2 * XLEN;

  function automatic int rows_at(
    input int l
  );
    int n;
    n = XLEN;
    for (int i = 0; i < l; i++)
      n = n - wallace_cmp(n);
    return n;
  endfunction

  logic [W-1:0] lvl [XLEN+1][XLEN];

  for (genvar i = 0; i < XLEN; i++) begin : g_pp
    assign lvl[0][i] = b_i[i] ? (W'(a_i) << i) : '0;
  end

  for (genvar l = 0; l < XLEN; l++) begin : g_lvl
    localparam int N = rows_at(l);
    localparam int G = wallace_cmp(N);
    localparam int M = N - G;
    for (genvar j = 0; j < XLEN; j++) begin : g_row
      localparam int K = 3 * (j / 2);
      if (j < 2 * G && j % 2 == 0) begin : g_s
        assign lvl[l+1][j] = lvl[l][K] ^
                             lvl[l][K+1] ^
                             lvl[l][K+2];
      end else if (j < 2 * G) begin : g_c
        assign lvl[l+1][j] =
          ((lvl[l][K] & lvl[l][K+1]) |
           (lvl[l][K] & lvl[l][K+2]) |
           (lvl[l][K+1] & lvl[l][K+2])) << 1;
      end else if (j < M) begin : g_p
        assign lvl[l+1][j] = lvl[l][j+G];
      end else begin : g_z
        assign lvl[l+1][j] = '0;
      end
    end
  end

  assign z0_o = lvl[XLEN][0];
  assign z1_o = lvl[XLEN][1];

endmodule

// File: rtl/mul_pipe.sv
// mul_pipe: 3-stage elastic RISC-V M-extension multiplier.
// Ports: clock/reset/flush; in_* request (valid/ready); out_* result.
module mul_pipe
  import mul_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TYP  = 0,
  parameter int TAGW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_res,
  output logic [2*XLEN-1:0] out_prod,
  output logic [TAGW-1:0]   out_tag
);

  localparam int W = 2 * XLEN;

  typedef struct packed {
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            neg;
    logic [1:0]      op;
    logic [TAGW-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [W-1:0]    z0;
    logic [W-1:0]    z1;
    logic            neg;
    logic [1:0]      op;
    logic [TAGW-1:0] tag;
  } s2_t;

  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  logic            s1_v_q, s1_v_d;
  logic            s2_v_q, s2_v_d;
  logic            s3_v_q, s3_v_d;
  logic [W-1:0]    prod_q, prod_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [TAGW-1:0] tag_q;
  logic            s1_adv, s2_adv;
  logic            accept;
  logic            sgn_a, sgn_b;
  logic [W-1:0]    z0, z1, sum;

  assign s2_adv   = s2_v_q && (!s3_v_q || out_ready);
  assign s1_adv   = s1_v_q && (!s2_v_q || s2_adv);
  assign in_ready = !s1_v_q || s1_adv;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    sgn_a = op_a_signed(in_op) & in_a[XLEN-1];
    sgn_b = op_b_signed(in_op) & in_b[XLEN-1];
    s1_d.mag_a = sgn_a ? (~in_a + XLEN'(1)) : in_a;
    s1_d.mag_b = sgn_b ? (~in_b + XLEN'(1)) : in_b;
    s1_d.neg   = sgn_a ^ sgn_b;
    s1_d.op    = in_op;
    s1_d.tag   = in_tag;
  end

  if (TYP == 1) begin : g_wallace
    wallace #(.XLEN(XLEN)) u_tree (
      .a_i  (s1_q.mag_a),
      .b_i  (s1_q.mag_b),
      .z0_o (z0),
      .z1_o (z1)
    );
  end else begin : g_dadda
    dadda #(.XLEN(XLEN)) u_tree (
      .a_i  (s1_q.mag_a),
      .b_i  (s1_q.mag_b),
      .z0_o (z0),
      .z1_o (z1)
    );
  end

  always_comb begin
    s2_d.z0  = z0;
    s2_d.z1  = z1;
    s2_d.neg = s1_q.neg;
    s2_d.op  = s1_q.op;
    s2_d.tag = s1_q.tag;
  end

  assign sum    = s2_q.z0 + s2_q.z1;
  assign prod_d = s2_q.neg ? (~sum + W'(1)) : sum;
  assign res_d  = op_hi(s2_q.op) ?
                  prod_d[W-1:XLEN] :
                  prod_d[XLEN-1:0];

  always_comb begin
    s1_v_d = accept | (s1_v_q & ~s1_adv);
    s2_v_d = s1_adv | (s2_v_q & ~s2_adv);
    s3_v_d = s2_adv | (s3_v_q & ~out_ready);
    if (flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
      s3_v_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s3_v_q <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      prod_q <= '0;
      res_q  <= '0;
      tag_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s3_v_q <= s3_v_d;
      if (accept) s1_q <= s1_d;
      if (s1_adv) s2_q <= s2_d;
      if (s2_adv) begin
        prod_q <= prod_d;
        res_q  <= res_d;
        tag_q  <= s2_q.tag;
      end
    end
  end

  assign out_valid = s3_v_q;
  assign out_res   = res_q;
  assign out_prod  = prod_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: drives a dadda (TYP=0) and a wallace (TYP=1) mul_pipe
// in lockstep and checks both against a plain-arithmetic product model.
module tb_mul_pipe;
  import mul_pipe_pkg::*;

  logic        clock = 0;
  logic        reset = 1;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        out_ready = 0;
  logic [1:0]  in_op = 0;
  logic [31:0] in_a = 0;
  logic [31:0] in_b = 0;
  logic [4:0]  in_tag = 0;

  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [31:0] out_res0, out_res1;
  logic [63:0] out_prod0, out_prod1;
  logic [4:0]  out_tag0, out_tag1;

  typedef struct packed {
    logic [31:0] res;
    logic [63:0] prod;
    logic [4:0]  tag;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs0_q[$];
  rec_t obs1_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  mul_pipe #(.XLEN(32), .TYP(0), .TAGW(5)) u_dut0 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_tag(in_tag), .out_valid(out_valid0),
    .out_ready(out_ready), .out_res(out_res0),
    .out_prod(out_prod0), .out_tag(out_tag0)
  );

  mul_pipe #(.XLEN(32), .TYP(1), .TAGW(5)) u_dut1 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_tag(in_tag), .out_valid(out_valid1),
    .out_ready(out_ready), .out_res(out_res1),
    .out_prod(out_prod1), .out_tag(out_tag1)
  );

  function automatic rec_t model(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  tag
  );
    longint ea, eb;
    logic [63:0] p;
    rec_t r;
    ea = (op == MUL_OP_MULH || op == MUL_OP_MULHSU) ?
         longint'($signed(a)) : longint'({32'b0, a});
    eb = (op == MUL_OP_MULH) ?
         longint'($signed(b)) : longint'({32'b0, b});
    p = ea * eb;
    r.prod = p;
    r.res  = (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
    r.tag  = tag;
    return r;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_rand();
    in_op  = 2'($urandom);
    in_a   = rnd_opnd();
    in_b   = rnd_opnd();
    in_tag = 5'($urandom);
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs0_q.delete();
    obs1_q.delete();
  endtask

  // One cycle: log handshakes, let the edge happen, return at negedge.
  task automatic step();
    rec_t r;
    #1;
    if (out_valid0 && out_ready) begin
      r = {out_res0, out_prod0, out_tag0};
      obs0_q.push_back(r);
    end
    if (out_valid1 && out_ready) begin
      r = {out_res1, out_prod1, out_tag1};
      obs1_q.push_back(r);
    end
    if (in_valid && in_ready0 && !flush)
      exp_q.push_back(model(in_op, in_a, in_b, in_tag));
    if (flush)
      while (exp_q.size() > obs0_q.size())
        void'(exp_q.pop_back());
    @(negedge clock);
  endtask

  task automatic test_reset();
    #2 reset = 0;
    @(negedge clock);
    #1;
    vectors++;
    if ({out_valid0, out_res0, out_prod0, out_tag0} !== '0 ||
        {out_valid1, out_res1, out_prod1, out_tag1} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: got v=%b/%b res=%h prod=%h tag=%h, want all 0",
               out_valid0, out_valid1, out_res0, out_prod0, out_tag0);
    end
    reset = 1;
    #1;
    vectors++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b/%b, want 1",
               in_ready0, in_ready1);
    end
    @(negedge clock);
  endtask

  task automatic test_vectors();
    logic [1:0]  vop [8] = '{MUL_OP_MULHU, MUL_OP_MUL,
                             MUL_OP_MULH, MUL_OP_MULH,
                             MUL_OP_MULHSU, MUL_OP_MULH,
                             MUL_OP_MULHU, MUL_OP_MULH};
    logic [31:0] va [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'h80000000, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'h7FFFFFFF,
                            32'h00000000, 32'h00000000};
    logic [31:0] vb [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'h80000000, 32'h00000001,
                            32'hFFFFFFFF, 32'h80000000,
                            32'h12345678, 32'h80000000};
    logic [31:0] vres [8] = '{32'hFFFFFFFE, 32'h00000001,
                              32'h40000000, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'hC0000000,
                              32'h0, 32'h0};
    logic [63:0] vprod [8] = '{64'hFFFFFFFE00000001,
                               64'hFFFFFFFE00000001,
                               64'h4000000000000000,
                               64'hFFFFFFFFFFFFFFFF,
                               64'hFFFFFFFF00000001,
                               64'hC000000080000000,
                               64'h0, 64'h0};
    rec_t want, got0, got1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_op = vop[i];
      in_a = va[i]; in_b = vb[i];
      in_tag = 5'(i); out_ready = 1; flush = 0;
      @(negedge clock);
      in_valid = 0;
      for (int c = 1; c <= 3; c++) begin
        #1;
        vectors++;
        if (out_valid0 !== (c == 3) ||
            out_valid1 !== (c == 3)) begin
          miscompares++;
          $display("FAIL vec%0d_latency c%0d: got %b/%b, want %b",
                   i, c, out_valid0, out_valid1, c == 3);
        end
        if (c < 3) @(negedge clock);
      end
      want = {vres[i], vprod[i], 5'(i)};
      got0 = {out_res0, out_prod0, out_tag0};
      got1 = {out_res1, out_prod1, out_tag1};
      vectors++;
      if (got0 !== want || got1 !== want) begin
        miscompares++;
        $display("FAIL vec%0d: got res=%h/%h prod=%h/%h, want res=%h prod=%h",
                 i, got0.res, got1.res, got0.prod, got1.prod,
                 want.res, want.prod);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    int   sent;
    logic acc;
    sent = 0;
    clear_q();
    flush = 0; in_valid = 1;
    drive_rand(); in_tag = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 8);
      #1;
      if (cyc >= 4 && cyc <= 8) begin
        vectors++;
        if (in_ready0 !== 0 || in_ready1 !== 0 ||
            out_valid0 !== 1 || out_tag0 !== 5'd1 ||
            out_prod0 !== exp_q[1].prod ||
            out_tag1 !== 5'd1) begin
          miscompares++;
          $display("FAIL bp_hold c%0d: got rdy=%b/%b v=%b tag=%0d/%0d, want rdy=0 v=1 tag=1",
                   cyc, in_ready0, in_ready1, out_valid0,
                   out_tag0, out_tag1);
        end
      end
      if (cyc == 8) begin
        vectors++;
        if (exp_q.size() - obs0_q.size() !== 3) begin
          miscompares++;
          $display("FAIL bp_held_count: got %0d, want 3",
                   exp_q.size() - obs0_q.size());
        end
      end
      acc = in_valid && in_ready0;
      step();
      if (acc) begin
        sent++;
        if (sent < 8) begin
          drive_rand(); in_tag = 5'(sent);
        end else in_valid = 0;
      end
      if (obs0_q.size() == 8) break;
    end
    vectors++;
    if (exp_q.size() !== 8 || obs0_q.size() !== 8 ||
        obs1_q.size() !== 8) begin
      miscompares++;
      $display("FAIL bp_count: got %0d/%0d of %0d, want 8",
               obs0_q.size(), obs1_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs0_q.size() && i < obs1_q.size()) begin
        vectors++;
        if (obs0_q[i] !== exp_q[i] ||
            obs1_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL bp[%0d]: got tag=%0d/%0d prod=%h/%h, want tag=%0d prod=%h",
                   i, obs0_q[i].tag, obs1_q[i].tag,
                   obs0_q[i].prod, obs1_q[i].prod,
                   exp_q[i].tag, exp_q[i].prod);
        end
      end
    end
  endtask

  task automatic test_flush();
    rec_t want, got0, got1;
    flush = 0; out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; drive_rand();
      #1;
      vectors++;
      if (in_ready0 !== 1 || in_ready1 !== 1) begin
        miscompares++;
        $display("FAIL flush_fill%0d: got rdy=%b/%b, want 1",
                 k, in_ready0, in_ready1);
      end
      @(negedge clock);
    end
    drive_rand(); in_valid = 1; flush = 1;
    #1;
    vectors++;
    if (in_ready0 !== 0 || in_ready1 !== 0) begin
      miscompares++;
      $display("FAIL flush_pre_ready: got %b/%b, want 0",
               in_ready0, in_ready1);
    end
    @(negedge clock);
    flush = 0; in_valid = 0; out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++;
      if (out_valid0 !== 0 || out_valid1 !== 0 ||
          (c == 0 && (in_ready0 !== 1 || in_ready1 !== 1))) begin
        miscompares++;
        $display("FAIL flush_drain c%0d: got v=%b/%b rdy=%b, want v=0 rdy=1",
                 c, out_valid0, out_valid1, in_ready0);
      end
      @(negedge clock);
    end
    in_valid = 1; drive_rand(); flush = 1;
    #1;
    vectors++;
    if (in_ready0 !== 1 || in_ready1 !== 1) begin
      miscompares++;
      $display("FAIL flush_empty_ready: got %b/%b, want 1",
               in_ready0, in_ready1);
    end
    @(negedge clock);
    flush = 0; in_valid = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++;
      if (out_valid0 !== 0 || out_valid1 !== 0) begin
        miscompares++;
        $display("FAIL flush_prio c%0d: got v=%b/%b, want 0",
                 c, out_valid0, out_valid1);
      end
      @(negedge clock);
    end
    in_valid = 1; drive_rand();
    want = model(in_op, in_a, in_b, in_tag);
    @(negedge clock);
    in_valid = 0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      vectors++;
      if (out_valid0 !== (c == 3) ||
          out_valid1 !== (c == 3)) begin
        miscompares++;
        $display("FAIL flush_next_lat c%0d: got %b/%b, want %b",
                 c, out_valid0, out_valid1, c == 3);
      end
      if (c < 3) @(negedge clock);
    end
    got0 = {out_res0, out_prod0, out_tag0};
    got1 = {out_res1, out_prod1, out_tag1};
    vectors++;
    if (got0 !== want || got1 !== want) begin
      miscompares++;
      $display("FAIL flush_next: got res=%h/%h prod=%h/%h, want res=%h prod=%h",
               got0.res, got1.res, got0.prod, got1.prod,
               want.res, want.prod);
    end
    @(negedge clock);
  endtask

  task automatic test_async_reset();
    clear_q();
    out_ready = 1; flush = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1; drive_rand();
      step();
    end
    in_valid = 0;
    #1;
    vectors++;
    if (out_valid0 !== 1 || out_valid1 !== 1) begin
      miscompares++;
      $display("FAIL areset_pre: got v=%b/%b, want 1",
               out_valid0, out_valid1);
    end
    #1 reset = 0;
    #1;
    vectors++;
    if ({out_valid0, out_res0, out_prod0, out_tag0} !== '0 ||
        {out_valid1, out_res1, out_prod1, out_tag1} !== '0) begin
      miscompares++;
      $display("FAIL areset_outs: got v=%b/%b res=%h prod=%h tag=%h, want all 0",
               out_valid0, out_valid1, out_res0, out_prod0, out_tag0);
    end
    @(negedge clock);
    #2 reset = 1;
    #1;
    vectors++;
    if (in_ready0 !== 1 || in_ready1 !== 1) begin
      miscompares++;
      $display("FAIL areset_ready: got %b/%b, want 1",
               in_ready0, in_ready1);
    end
    @(negedge clock);
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++;
      if (out_valid0 !== 0 || out_valid1 !== 0) begin
        miscompares++;
        $display("FAIL areset_survivor c%0d: got v=%b/%b, want 0",
                 c, out_valid0, out_valid1);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      drive_rand();
      step();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    for (int k = 0; k < 12; k++) step();
    vectors++;
    if (obs0_q.size() !== exp_q.size() ||
        obs1_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL rand_count: got %0d/%0d, want %0d",
               obs0_q.size(), obs1_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs0_q.size() && i < obs1_q.size()) begin
        vectors++;
        if (obs0_q[i] !== exp_q[i] ||
            obs1_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rand[%0d]: got res=%h/%h prod=%h/%h tag=%0d, want res=%h prod=%h tag=%0d",
                   i, obs0_q[i].res, obs1_q[i].res,
                   obs0_q[i].prod, obs1_q[i].prod,
                   obs0_q[i].tag, exp_q[i].res,
                   exp_q[i].prod, exp_q[i].tag);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
